// File: rtl/mac512_sa_cla.sv
// rtl/mac512_sa_cla.sv - shift-add 256x256 MAC with CLA adders and 512-bit accumulator (option: MAC512_ACC_SAT_EN)

// Carry-lookahead adder: lookahead inside each CLA_GROUP-bit group, group carries chained by group G/P.
module mac512_sa_cla_adder #(
    parameter int W = 512,
    parameter int G = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         co
);
    localparam int NG = W / G;

    logic [W-1:0] gen;
    logic [W-1:0] prop;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Per-bit carries come from the group's prefix G/P and the group carry-in only
    always_comb begin
        logic carry;
        logic gacc;
        logic pacc;
        carry = 1'b0;
        sum   = '0;
        for (int k = 0; k < NG; k++) begin
            gacc = 1'b0;
            pacc = 1'b1;
            for (int i = 0; i < G; i++) begin
                sum[k*G+i] = prop[k*G+i] ^ (gacc | (pacc & carry));
                gacc = gen[k*G+i] | (prop[k*G+i] & gacc);
                pacc = pacc & prop[k*G+i];
            end
            carry = gacc | (pacc & carry);
        end
        co = carry;
    end
endmodule

module mac512_sa_cla #(
    parameter int WIDTH     = 256,
    parameter int CLA_GROUP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   out
);
    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, ACC} state_t;

    state_t          state;
    logic [AW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [AW-1:0]   prod;
    logic [CW-1:0]   cnt;

    logic [AW-1:0]   prod_sum;
    logic [AW-1:0]   acc_sum;
    logic [AW-1:0]   acc_next;
    logic            prod_co_unused;
    logic            acc_co;

    // The product never exceeds 2*WIDTH bits, so this carry-out is meaningless
    mac512_sa_cla_adder #(.W(AW), .G(CLA_GROUP)) u_prod_add (
        .a   (prod),
        .b   (mcand),
        .sum (prod_sum),
        .co  (prod_co_unused)
    );

    mac512_sa_cla_adder #(.W(AW), .G(CLA_GROUP)) u_acc_add (
        .a   (out),
        .b   (prod),
        .sum (acc_sum),
        .co  (acc_co)
    );

`ifdef MAC512_ACC_SAT_EN
    // Clamp to all ones on accumulator overflow; an all-ones value stays saturated
    always_comb begin
        acc_next = acc_co ? {AW{1'b1}} : acc_sum;
    end
`else
    logic acc_co_unused;
    assign acc_co_unused = acc_co;

    // Accumulator wraps modulo 2^(2*WIDTH)
    always_comb begin
        acc_next = acc_sum;
    end
`endif

    // Control FSM and datapath registers: load, one shift-add step per enabled RUN edge, accumulate
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state  <= IDLE;
            out    <= '0;
            prod   <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        prod   <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (mplier[0]) begin
                            prod <= prod_sum;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                        if (cnt == CNT_LAST) begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    out <= acc_next;
                    if (en) begin
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        prod   <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac512_sa_cla.sv
// tb/tb_mac512_sa_cla.sv - directed self-checking bench for mac512_sa_cla

module tb_mac512_sa_cla;
    localparam int WIDTH = 256;
    localparam int AW    = 2 * WIDTH;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [AW-1:0]    out;

    int n_checks;
    int n_errors;

    logic [AW-1:0] full_once;
    logic [AW-1:0] full_twice;

    mac512_sa_cla #(.WIDTH(WIDTH), .CLA_GROUP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (A),
        .B     (B),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, ending at the following falling edge
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        en    = 1'b0;
        edges(1);
        rst_n = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1;
        en    = 1'b0;
        A     = '0;
        B     = '0;
        edges(2);
        check("reset_state", out, '0);
        rst_n = 1'b0;

        // Random activity, then reset with en still high: reset wins
        A  = {8{$urandom()}};
        B  = {8{$urandom()}};
        en = 1'b1;
        edges(600);
        rst_n = 1'b1;
        edges(1);
        check("reset_after_activity", out, '0);
        rst_n = 1'b0;
        en    = 1'b0;
        edges(500);
        check("idle_500", out, '0);
        edges(500);
        check("idle_1000", out, '0);

        // 32x32 back-to-back, then operand changes mid-run
        A  = 256'd32;
        B  = 256'd32;
        en = 1'b1;
        edges(257);
        check("e257_zero", out, '0);
        edges(1);
        check("e258_1024", out, 512'd1024);
        edges(256);
        check("e514_stable", out, 512'd1024);
        edges(1);
        check("e515_2048", out, 512'd2048);
        edges(257);
        check("e772_3072", out, 512'd3072);
        edges(100);
        A = 256'd5;
        B = 256'd10;
        edges(157);
        check("midchange_still_1024", out, 512'd4096);
        edges(100);
        A = 256'd100;
        B = 256'd100;
        edges(157);
        check("next_adds_50", out, 512'd4146);
        edges(257);
        check("next_adds_10000", out, 512'd14146);

        // Full-scale operands
        do_reset();
        check("reset_before_full", out, '0);
        full_once  = '0;
        full_once  = full_once - (512'd1 << 257) + 512'd1;
        full_twice = full_once + full_once;
`ifdef MAC512_ACC_SAT_EN
        full_twice = '1;
`endif
        A  = '1;
        B  = '1;
        en = 1'b1;
        edges(258);
        check("full_first", out, full_once);
        edges(257);
        check("full_second", out, full_twice);

        // Pause in RUN delays the result by the paused cycles only
        do_reset();
        A  = 256'd3;
        B  = 256'd7;
        en = 1'b1;
        edges(100);
        en = 1'b0;
        edges(10);
        check("pause_frozen", out, '0);
        en = 1'b1;
        edges(157);
        check("pause_e267_zero", out, '0);
        edges(1);
        check("pause_e268_21", out, 512'd21);

        // Reset in the middle of a run discards the partial product
        do_reset();
        A  = 256'd32;
        B  = 256'd32;
        en = 1'b1;
        edges(258);
        check("pre_midreset_1024", out, 512'd1024);
        edges(100);
        rst_n = 1'b1;
        edges(1);
        check("midrun_reset_zero", out, '0);
        rst_n = 1'b0;
        edges(257);
        check("after_reset_e257_zero", out, '0);
        edges(1);
        check("after_reset_e258_1024", out, 512'd1024);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mac512_sa_cla.md
# mac512_sa_cla

- 256×256-bit multiply-accumulate unit with a 512-bit accumulator output.
- Each product is built by a sequential shift-add multiplier, one multiplier bit per clock.
- Partial-product and accumulate additions use a carry-lookahead adder.
- It is a compact, area-lean datapath block: long latency, no per-result handshake, and results are read from the running accumulator `out`.

## Interface
- `WIDTH`, default 256: operand width; accumulator is 2*WIDTH bits; one product takes WIDTH shift-add cycles.
- `CLA_GROUP`, default 4: carry-lookahead group size in bits; the adder is a hierarchical CLA over 2*WIDTH bits.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous reset, active-high despite the suffix. Sampled only at the rising edge of `clk`.
- `en`  input  1  run enable.
- `A`  input  WIDTH  multiplicand, sampled at operand-load edges only.
- `B`  input  WIDTH  multiplier, sampled at operand-load edges only.
- `out`  output  2*WIDTH  registered accumulator, the sum of all completed products.

## Operation
- The FSM has three states: IDLE, RUN and ACC. Internal state:
  - `mcand`, 2*WIDTH bits
  - `mplier`, WIDTH bits
  - `prod`, 2*WIDTH bits
  - `cnt`, log2(WIDTH) bits
- Reset (`rst_n`=1 at an edge) sets `out`=0, `prod`=0, `cnt`=0 and state=IDLE. Reset has priority over everything else.
- In IDLE with `en`=1, the next edge is an operand load:
  - `mcand`={WIDTH'b0, A}, `mplier`=B, `prod`=0, `cnt`=0.
  - State goes to RUN.
- In IDLE with `en`=0, state is held.
- Each RUN edge with `en`=1 does one shift-add step:
  - If `mplier[0]`, `prod` <= `prod` + `mcand` (CLA); otherwise `prod` is held.
  - `mcand` <<= 1, `mplier` >>= 1, `cnt`++.
  - On the step where `cnt`==WIDTH-1, state goes to ACC.
- In RUN with `en`=0, all state is frozen (pause). There is no abort.
- On the ACC edge:
  - `out` <= `out` + `prod` (CLA), modulo 2^(2*WIDTH).
  - If `en`=1, perform an operand load in the same edge and go to RUN; otherwise go to IDLE.
- `A`/`B` changes outside load edges have no effect on the product in flight.
- The product is exact: `prod` never overflows 2*WIDTH bits.
- Accumulator overflow wraps silently (default build).

## Timing
- Sequence with `en` held at 1 from IDLE:
  - Load at edge 1, RUN steps at edges 2..257, accumulate at edge 258.
  - Each later result lands every 257 edges (edges 515, 772, ...).
- `out` changes only on ACC edges or reset. It is stable for the other 256 cycles of each period.
- Latency from `A`/`B` capture to its contribution visible on `out`: 257 edges, plus one edge per `en`=0 cycle spent in RUN.
- Reset mid-RUN or mid-ACC discards the partial product. `out`=0 after that edge and state=IDLE.
- If `rst_n` and `en` are both 1 at an edge, reset wins.
- Critical path: one 2*WIDTH-bit CLA addition plus the FSM. All outputs are registered.

## Configuration
- `MAC512_ACC_SAT_EN`
  - Defined: the ACC-edge addition saturates. If `out`+`prod` ≥ 2^(2*WIDTH), `out` becomes all ones and stays there, since further additions stay saturated until reset.
  - Undefined: the accumulator wraps modulo 2^(2*WIDTH).
  - The multiplier datapath is identical in both builds.

## Test plan
- Reset: `rst_n`=1 for one edge after random activity -> `out`=0, and with `en`=0 `out` stays 0 for 1000 cycles.
- A=B=32, `en`=1 from IDLE -> `out`=0 through edge 257, 1024 at edge 258, 2048 at edge 515, 3072 at edge 772.
- Operand change mid-run:
  - Change to A=5, B=10 during the second 32×32 run -> that run still adds 1024.
  - The next period adds 50. Then change to A=B=100 -> the following period adds 10000.
- Full-scale operands: A=B=2^256−1.
  - First ACC -> `out`=2^512−2^257+1.
  - Second ACC -> `out`=(2·(2^512−2^257+1)) mod 2^512 with wrap, or all ones with `MAC512_ACC_SAT_EN`.
- Pause: A=3, B=7, drop `en` for 10 cycles mid-RUN -> `out`=21 appears at edge 268 instead of 258; the value is unchanged by the pause.
- Reset mid-RUN at cycle 100 of a 32×32 operation that follows one completed product (`out`=1024) -> `out`=0; the next 32×32 product with `en`=1 gives `out`=1024 after 258 edges.
